hex_scan_driver: RTL and testbench

Time-multiplexed scan driver for a multi-digit common-anode seven-segment display. Holds a packed hex value, and each scan slot presents one 4-bit digit code on `nibble` for the shared 4-bit segment decoder, along with an active-low digit enable. New values are double-buffered and take effect only at a frame boundary, so a displayed number never tears. Optional leading-zero blanking and a one-cycle dark interval per slot suppress ghosting.

---
 rtl/hex_scan_driver_pkg.sv | 28 ++
 rtl/hex_scan_driver_scan_tick_gen.sv | 29 ++
 rtl/hex_scan_driver.sv | 89 ++++++++
 tb/tb_hex_scan_driver.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/hex_scan_driver_pkg.sv
// Shared constants and helpers for the seven-segment display blocks.
// blank_mask marks the leading-zero slots of a packed display value.
package hex_scan_driver_pkg;

  localparam int CODE_W     = 4;
  localparam int MAX_DIGITS = 16;

  // Slot k is blanked when k > 0 and every digit from k upward is zero.
  function automatic logic [MAX_DIGITS-1:0] blank_mask(
    input logic [CODE_W*MAX_DIGITS-1:0] disp,
    input int                           digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_above;
    mask       = {MAX_DIGITS{1'b0}};
    zero_above = 1'b1;
    for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
      if (k < digits) begin
        zero_above = zero_above & (disp[CODE_W*k +: CODE_W] == {CODE_W{1'b0}});
        mask[k]    = zero_above & (k != 0);
      end else begin
        mask[k] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/hex_scan_driver_scan_tick_gen.sv
// Slot prescaler: tick marks the last cycle of a slot, dark marks the first.
module scan_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic dark
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_r;

  assign tick = (cnt_r == CNT_W'(TICK_DIV - 1));
  assign dark = (cnt_r == {CNT_W{1'b0}});

  // Prescaler counting 0..TICK_DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (tick) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hex_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous double
// buffering, leading-zero blanking and a dark cycle at the start of each slot.
module hex_scan_driver
  import hex_scan_driver_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [CODE_W*DIGITS-1:0] value_in,
  input  logic                     blank_lz,
  output logic [CODE_W-1:0]        nibble,
  output logic [DIGITS-1:0]        digit_en,
  output logic                     pending,
  output logic                     frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int VAL_W = CODE_W * DIGITS;
  localparam logic [DIGITS-1:0] SLOT0_SEL = {{(DIGITS-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0]             idx_r;
  logic [VAL_W-1:0]             shadow_r;
  logic [VAL_W-1:0]             disp_r;
  logic                         pending_r;
  logic                         frame_done_r;
  logic                         tick_s;
  logic                         dark_s;
  logic                         wrap_s;
  logic [CODE_W*MAX_DIGITS-1:0] disp_ext_s;
  logic [MAX_DIGITS-1:0]        mask_s;

  scan_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick_s),
    .dark (dark_s)
  );

  assign wrap_s     = tick_s & (idx_r == IDX_W'(DIGITS - 1));
  assign pending    = pending_r;
  assign frame_done = frame_done_r;

  // Slot index, shadow/display buffers and frame status.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r        <= {IDX_W{1'b0}};
      shadow_r     <= {VAL_W{1'b0}};
      disp_r       <= {VAL_W{1'b0}};
      pending_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= wrap_s;
      if (tick_s) begin
        idx_r <= (idx_r == IDX_W'(DIGITS - 1)) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
      end
      if (load) begin
        shadow_r <= value_in;
      end
      // A load on the wrap edge goes straight to the display, so pending ends low.
      if (wrap_s) begin
        if (pending_r || load) begin
          disp_r <= load ? value_in : shadow_r;
        end
        pending_r <= 1'b0;
      end else if (load) begin
        pending_r <= 1'b1;
      end
    end
  end

  // Digit code and active-low enable for the current slot.
  always_comb begin
    disp_ext_s               = {(CODE_W*MAX_DIGITS){1'b0}};
    disp_ext_s[VAL_W-1:0]    = disp_r;
    mask_s                   = blank_mask(disp_ext_s, DIGITS);
    nibble                   = disp_r[CODE_W*idx_r +: CODE_W];
    if (dark_s || (blank_lz && mask_s[idx_r])) begin
      digit_en = {DIGITS{1'b1}};
    end else begin
      digit_en = ~(SLOT0_SEL << idx_r);
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Scoreboard bench for hex_scan_driver with DIGITS=4, TICK_DIV=4 (16-cycle frame).
module tb_hex_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  nibble;
  logic [3:0]  digit_en;
  logic        pending;
  logic        frame_done;

  hex_scan_driver #(.DIGITS(4), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .load(load), .value_in(value_in),
    .blank_lz(blank_lz), .nibble(nibble), .digit_en(digit_en),
    .pending(pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] nib;
    logic [3:0] en;
    logic       pend;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference state: p = rising edges since reset (frame position).
  int          p = 0;
  logic [15:0] m_disp = 16'h0000;
  logic [15:0] m_shadow = 16'h0000;
  logic        m_pend = 1'b0;
  logic        m_fd = 1'b0;

  logic [3:0] lit_n [4];
  logic [3:0] lit_e [4];

  logic cont = 1'b0;
  int   mon_cyc = 0;
  int   last_fd = -1;

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Monitor: sample #1 after each rising edge and compare against the queue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    mon_cyc++;
    check("onehot_low", {3'b000, ($countones(~digit_en) > 1)}, 4'h0);
    if (cont && frame_done === 1'b1) begin
      if (last_fd >= 0) check("fd_interval", 4'(mon_cyc - last_fd), 4'(16));
      last_fd = mon_cyc;
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.name, ".nibble"}, nibble, e.nib);
      check({e.name, ".digit_en"}, digit_en, e.en);
      check({e.name, ".pending"}, {3'b000, pending}, {3'b000, e.pend});
      check({e.name, ".frame_done"}, {3'b000, frame_done}, {3'b000, e.fd});
    end
  end

  // One clock of stimulus; lit=1 uses the caller's hand-written expectation.
  task automatic cyc(input logic rst, input logic ld, input logic [15:0] v, input logic blz,
                     input string nm, input logic lit, input logic [3:0] ln,
                     input logic [3:0] le, input logic lp, input logic lf);
    exp_t e;
    int slot;
    int c;
    reset = rst; load = ld; value_in = v; blank_lz = blz;
    if (rst) begin
      p = 0; m_disp = 16'h0000; m_shadow = 16'h0000; m_pend = 1'b0; m_fd = 1'b0;
    end else begin
      m_fd = ((p % 16) == 15);
      if (ld) m_shadow = v;
      if (m_fd) begin
        if (m_pend || ld) m_disp = m_shadow;
        m_pend = 1'b0;
      end else if (ld) begin
        m_pend = 1'b1;
      end
      p++;
    end
    slot = (p / 4) % 4;
    c = p % 4;
    e.name = nm;
    if (lit) begin
      e.nib = ln; e.en = le; e.pend = lp; e.fd = lf;
    end else begin
      e.nib = 4'((m_disp >> (4 * slot)) & 16'h000F);
      if (c == 0 || (blz && slot > 0 && (m_disp >> (4 * slot)) == 16'h0000))
        e.en = 4'b1111;
      else
        e.en = ~(4'b0001 << slot);
      e.pend = m_pend; e.fd = m_fd;
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic mcyc(input logic rst, input logic ld, input logic [15:0] v,
                      input logic blz, input string nm);
    cyc(rst, ld, v, blz, nm, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic to_wrap(input logic blz, input string nm);
    while ((p % 16) != 15) mcyc(1'b0, 1'b0, 16'h0000, blz, nm);
  endtask

  // Wrap edge plus the frame it starts, using lit_n/lit_e per slot.
  task automatic lit_frame(input logic ld, input logic [15:0] v, input logic blz, input string nm);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, (i == 0) ? ld : 1'b0, v, blz, nm, 1'b1, lit_n[i / 4],
          ((i % 4) == 0) ? 4'b1111 : lit_e[i / 4], 1'b0, (i == 0));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) mcyc(1'b1, 1'b0, 16'h0000, 1'b0, "reset_hold");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, "reset_release", 1'b1, 4'h0, 4'b1110, 1'b0, 1'b0);

    while (p != 6) mcyc(1'b0, 1'b0, 16'h0000, 1'b0, "pre_load");
    mcyc(1'b0, 1'b1, 16'h1A2F, 1'b0, "dbuf_load");
    to_wrap(1'b0, "dbuf_wait");
    lit_n = '{4'hF, 4'h2, 4'hA, 4'h1};
    lit_e = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    lit_frame(1'b0, 16'h0000, 1'b0, "dbuf_frame");

    mcyc(1'b0, 1'b1, 16'h0030, 1'b1, "blank_load");
    to_wrap(1'b1, "blank_wait");
    lit_n = '{4'h0, 4'h3, 4'h0, 4'h0};
    lit_e = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    lit_frame(1'b0, 16'h0000, 1'b1, "blank_0030");
    mcyc(1'b0, 1'b1, 16'h0000, 1'b1, "zero_load");
    to_wrap(1'b1, "zero_wait");
    lit_n = '{4'h0, 4'h0, 4'h0, 4'h0};
    lit_e = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    lit_frame(1'b0, 16'h0000, 1'b1, "blank_zero");
    for (int i = 0; i < 10; i++) mcyc(1'b0, 1'b0, 16'h0000, 1'b1, "blz_on");
    for (int i = 0; i < 16; i++) mcyc(1'b0, 1'b0, 16'h0000, 1'b0, "blz_off");

    mcyc(1'b0, 1'b1, 16'h1234, 1'b0, "sim_load1");
    to_wrap(1'b0, "sim_wait");
    lit_n = '{4'h8, 4'h7, 4'h6, 4'h5};
    lit_e = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    lit_frame(1'b1, 16'h5678, 1'b0, "sim_frame");

    while ((p % 16) != 5) mcyc(1'b0, 1'b0, 16'h0000, 1'b0, "mid_pre");
    mcyc(1'b0, 1'b1, 16'h9999, 1'b0, "mid_load");
    while ((p % 16) != 9) mcyc(1'b0, 1'b0, 16'h0000, 1'b0, "mid_slot2");
    for (int i = 0; i < 2; i++)
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, "mid_reset", 1'b1, 4'h0, 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) mcyc(1'b0, 1'b0, 16'h0000, 1'b0, "post_reset");

    mcyc(1'b0, 1'b1, 16'hC0DE, 1'b0, "cont_load");
    cont = 1'b1;
    for (int i = 0; i < 160; i++) mcyc(1'b0, 1'b0, 16'h0000, 1'b0, "continuous");
    cont = 1'b0;

    @(negedge clk);
    check("queue_drained", 4'(exp_q.size()), 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
